// File: rtl/cpu_register_bank.sv
// Register bank with one write port (load/increment/decrement/clear), two
// registered read ports with same-edge write forwarding, and carry/zero flags.
module cpu_register_bank #(
   parameter int WIDTH    = 4,
   parameter int NUM_REGS = 4,
   localparam int AW      = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       op,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] inputD,
   input  logic [AW-1:0]    raddr_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] outputA,
   output logic [WIDTH-1:0] outputB,
   output logic             carry,
   output logic             zero
);

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_INC   = 2'b01,
      OP_DEC   = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   localparam int NUM_SLOTS = 1 << AW;

   logic [WIDTH-1:0]     regs [NUM_REGS];
   logic [NUM_SLOTS-1:0] addr_ok;
   logic [WIDTH-1:0]     cur_val;
   logic [WIDTH-1:0]     rd_a;
   logic [WIDTH-1:0]     rd_b;
   logic [WIDTH-1:0]     result;
   logic                 result_carry;
   logic                 wr_ok;

   // Address slots beyond NUM_REGS exist only when NUM_REGS is not a power of two.
   for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_addr_ok
      assign addr_ok[g] = (g < NUM_REGS);
   end

   assign wr_ok = enable & addr_ok[waddr];

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      cur_val = '0;
      rd_a    = '0;
      rd_b    = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (waddr   == AW'(i)) cur_val = regs[i];
         if (raddr_a == AW'(i)) rd_a    = regs[i];
         if (raddr_b == AW'(i)) rd_b    = regs[i];
      end
   end

   always_comb begin
      result       = cur_val;
      result_carry = 1'b0;
      case (op_e'(op))
         OP_LOAD:  result = inputD;
         OP_INC:   {result_carry, result} = {1'b0, cur_val} + (WIDTH + 1)'(1);
         OP_DEC: begin
            result       = cur_val - WIDTH'(1);
            result_carry = (cur_val == '0);
         end
         OP_CLEAR: result = '0;
         default:  result = cur_val;
      endcase
   end

   // NOTE: the register array is reset too, because a reset must leave every register reading 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (waddr == AW'(i)) regs[i] <= result;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so all flops sample pre-edge values together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         outputA <= '0;
         outputB <= '0;
         carry   <= 1'b0;
         zero    <= 1'b0;
      end else begin
         outputA <= (wr_ok && raddr_a == waddr) ? result : rd_a;
         outputB <= (wr_ok && raddr_b == waddr) ? result : rd_b;
         if (wr_ok) begin
            carry <= result_carry;
            zero  <= (result == '0);
         end
      end
   end

endmodule

// File: tb/tb_cpu_register_bank.sv
// Self-checking bench: a 4-register and a 3-register instance, directed scenarios
// plus random traffic, all compared against an arithmetic reference model.
module tb_cpu_register_bank;

   logic       clk;
   logic       reset;
   logic       en  [2];
   logic [1:0] opc [2];
   logic [1:0] wa  [2];
   logic [3:0] din [2];
   logic [1:0] ra  [2];
   logic [1:0] rb  [2];
   logic [3:0] oa  [2];
   logic [3:0] ob  [2];
   logic       cy  [2];
   logic       zr  [2];

   int n_checks = 0;
   int n_fail   = 0;

   int nregs [2] = '{4, 3};
   int m_reg [2][4];
   int m_oa  [2];
   int m_ob  [2];
   int m_cy  [2];
   int m_zr  [2];

   cpu_register_bank #(.WIDTH(4), .NUM_REGS(4)) dut0 (
      .clk(clk), .reset(reset), .enable(en[0]), .op(opc[0]), .waddr(wa[0]),
      .inputD(din[0]), .raddr_a(ra[0]), .raddr_b(rb[0]),
      .outputA(oa[0]), .outputB(ob[0]), .carry(cy[0]), .zero(zr[0])
   );

   cpu_register_bank #(.WIDTH(4), .NUM_REGS(3)) dut1 (
      .clk(clk), .reset(reset), .enable(en[1]), .op(opc[1]), .waddr(wa[1]),
      .inputD(din[1]), .raddr_a(ra[1]), .raddr_b(rb[1]),
      .outputA(oa[1]), .outputB(ob[1]), .carry(cy[1]), .zero(zr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
         m_oa[k] = 0; m_ob[k] = 0; m_cy[k] = 0; m_zr[k] = 0;
      end
   endtask

   // Applies the current inputs to the model as one rising edge.
   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         int r, res, c;
         if (en[k] && int'(wa[k]) < nregs[k]) begin
            r = m_reg[k][wa[k]];
            case (int'(opc[k]))
               0: begin res = int'(din[k]); c = 0; end
               1: begin res = (r + 1) % 16; c = (r == 15) ? 1 : 0; end
               2: begin res = (r + 15) % 16; c = (r == 0) ? 1 : 0; end
               default: begin res = 0; c = 0; end
            endcase
            m_reg[k][wa[k]] = res;
            m_cy[k] = c;
            m_zr[k] = (res == 0) ? 1 : 0;
         end
         m_oa[k] = (int'(ra[k]) < nregs[k]) ? m_reg[k][ra[k]] : 0;
         m_ob[k] = (int'(rb[k]) < nregs[k]) ? m_reg[k][rb[k]] : 0;
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("outA[%0d]", k), int'(oa[k]), m_oa[k]);
         check($sformatf("outB[%0d]", k), int'(ob[k]), m_ob[k]);
         check($sformatf("carry[%0d]", k), int'(cy[k]), m_cy[k]);
         check($sformatf("zero[%0d]", k), int'(zr[k]), m_zr[k]);
      end
   endtask

   task automatic drive(input int k, input logic e, input logic [1:0] o, input logic [1:0] w,
                        input logic [3:0] d, input logic [1:0] a, input logic [1:0] b);
      en[k] = e; opc[k] = o; wa[k] = w; din[k] = d; ra[k] = a; rb[k] = b;
   endtask

   task automatic idle();
      en[0] = 1'b0;
      en[1] = 1'b0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) drive(k, 1'b0, 2'd0, 2'd0, 4'd0, 2'd0, 2'd0);
      reset = 1'b1;
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      @(posedge clk);
      #1 check_all();
      drive(0, 1'b1, 2'd0, 2'd2, 4'hC, 2'd2, 2'd2);  // ignored while in reset
      @(posedge clk);
      #1 check_all();
      idle();
      #4 reset = 1'b1;
      #1;

      // Load r2 = A, read it the following cycle.
      drive(0, 1'b1, 2'd0, 2'd2, 4'hA, 2'd0, 2'd1);
      step();
      check("load_zero", int'(zr[0]), 0);
      check("load_carry", int'(cy[0]), 0);
      drive(0, 1'b0, 2'd0, 2'd0, 4'h0, 2'd2, 2'd0);
      step();
      check("read_r2", int'(oa[0]), 'hA);

      // r1 = F, increment wraps with carry, then increments to 1.
      drive(0, 1'b1, 2'd0, 2'd1, 4'hF, 2'd1, 2'd0);
      step();
      drive(0, 1'b1, 2'd1, 2'd1, 4'h0, 2'd1, 2'd0);
      step();
      check("inc_wrap_val", int'(oa[0]), 0);
      check("inc_wrap_carry", int'(cy[0]), 1);
      check("inc_wrap_zero", int'(zr[0]), 1);
      step();
      check("inc_again_val", int'(oa[0]), 1);
      check("inc_again_carry", int'(cy[0]), 0);
      check("inc_again_zero", int'(zr[0]), 0);

      // r0 = 0 decrements to F with borrow, then clear.
      drive(0, 1'b1, 2'd2, 2'd0, 4'h0, 2'd0, 2'd1);
      step();
      check("dec_wrap_val", int'(oa[0]), 'hF);
      check("dec_wrap_carry", int'(cy[0]), 1);
      check("dec_wrap_zero", int'(zr[0]), 0);
      drive(0, 1'b1, 2'd3, 2'd0, 4'h7, 2'd0, 2'd1);
      step();
      check("clear_val", int'(oa[0]), 0);
      check("clear_carry", int'(cy[0]), 0);
      check("clear_zero", int'(zr[0]), 1);

      // Same-edge forwarding to both ports.
      drive(0, 1'b1, 2'd0, 2'd3, 4'h5, 2'd3, 2'd3);
      step();
      check("fwd_a", int'(oa[0]), 5);
      check("fwd_b", int'(ob[0]), 5);

      // Back-to-back increments on r3 each count.
      drive(0, 1'b1, 2'd1, 2'd3, 4'h0, 2'd3, 2'd2);
      step();
      step();
      step();
      check("b2b_inc", int'(oa[0]), 8);
      idle();

      // 3-register instance: out-of-range write dropped, flags hold, read returns 0.
      drive(1, 1'b1, 2'd0, 2'd1, 4'h7, 2'd1, 2'd0);
      step();
      drive(1, 1'b1, 2'd0, 2'd2, 4'hF, 2'd2, 2'd1);
      step();
      drive(1, 1'b1, 2'd1, 2'd2, 4'h0, 2'd2, 2'd1);
      step();
      drive(1, 1'b1, 2'd0, 2'd3, 4'h9, 2'd3, 2'd3);
      step();
      check("oor_read_a", int'(oa[1]), 0);
      check("oor_read_b", int'(ob[1]), 0);
      check("oor_carry_hold", int'(cy[1]), 1);
      check("oor_zero_hold", int'(zr[1]), 1);
      drive(1, 1'b0, 2'd0, 2'd0, 4'h0, 2'd1, 2'd2);
      step();
      check("oor_r1_kept", int'(oa[1]), 7);
      check("oor_r2_kept", int'(ob[1]), 0);

      // Random traffic on both instances.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 2; k++) begin
            drive(k, logic'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         end
         step();
      end

      // Fill dut0 with nonzero values, then reset between edges with a write pending.
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 2'd0, 2'(i), 4'(i + 1), 2'(i), 2'd0);
         step();
      end
      drive(0, 1'b1, 2'd0, 2'd1, 4'hE, 2'd1, 2'd2);
      drive(1, 1'b1, 2'd0, 2'd0, 4'hE, 2'd0, 2'd0);
      #2 reset = 1'b0;
      model_reset();
      #1;
      check("rst_outA", int'(oa[0]), 0);
      check("rst_outB", int'(ob[0]), 0);
      check("rst_carry", int'(cy[0]), 0);
      check("rst_zero", int'(zr[0]), 0);
      check_all();
      @(posedge clk);
      #1 check_all();
      idle();
      #3 reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b0, 2'd0, 2'd0, 4'd0, 2'(i), 2'(3 - i));
         drive(1, 1'b0, 2'd0, 2'd0, 4'd0, 2'(i), 2'(3 - i));
         step();
         check($sformatf("post_rst_r%0d", i), int'(oa[0]), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
